// File: rtl/sobel_pkg.sv
// Shared constants for the streaming Sobel engine: FSM encodings,
// magnitude-mode selectors and gradient/absolute-value width offsets.
package sobel_pkg;

    // Frame-control FSM encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Magnitude selectors: exact L1 sum or max + min/2 approximation
    localparam int MAG_SUM    = 0;
    localparam int MAG_APPROX = 1;

    // Signed gradient is PIX_W+3 bits, its absolute value PIX_W+2 bits
    localparam int GRAD_EXTRA = 3;
    localparam int ABS_EXTRA  = 2;

endpackage

// File: rtl/sobel_line_buffer.sv
// Two-row line buffer for the Sobel window. For the current write column
// it presents the pixels of the two previous rows; on wr_en the older row
// entry is replaced by the newer one and the incoming pixel becomes the
// newer row entry. Storage is not reset.
module sobel_line_buffer #(
    parameter int IMG_WIDTH = 256,
    parameter int PIX_W     = 8,
    parameter int COL_W     = $clog2(IMG_WIDTH)
) (
    input  logic             clka,
    input  logic             wr_en,
    input  logic [COL_W-1:0] col,
    input  logic [PIX_W-1:0] pixel,
    output logic [PIX_W-1:0] top_pixel,
    output logic [PIX_W-1:0] mid_pixel
);

    logic [PIX_W-1:0] row_old [IMG_WIDTH];
    logic [PIX_W-1:0] row_new [IMG_WIDTH];

    assign top_pixel = row_old[col];
    assign mid_pixel = row_new[col];

    // Shift the column down one row and store the incoming pixel
    always_ff @(posedge clka) begin
        if (wr_en) begin
            row_old[col] <= row_new[col];
            row_new[col] <= pixel;
        end
    end

endmodule

// File: rtl/sobel_stream_engine.sv
// Streaming 3x3 Sobel edge detector. Raster pixels enter over valid/ready,
// one magnitude per interior pixel leaves over valid/ready through a
// three-stage pipeline (window, gradients, magnitude).
// Optional build macro SOBEL_THRESH_EN adds a thresh port and binarises
// the output magnitude.
module sobel_stream_engine
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = 256,
    parameter int IMG_HEIGHT = 256,
    parameter int PIX_W      = 8,
    parameter int MAG_MODE   = 1
) (
    input  logic             clka,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pixel,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef SOBEL_THRESH_EN
    input  logic [PIX_W-1:0] thresh,
`endif
    output logic [PIX_W-1:0] out_pixel,
    output logic             out_last,
    output logic [31:0]      cycle_count
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam int GW    = PIX_W + GRAD_EXTRA;
    localparam int AW    = PIX_W + ABS_EXTRA;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
    localparam logic [GW-1:0]    SAT_MAX  = {{GRAD_EXTRA{1'b0}}, {PIX_W{1'b1}}};

    // Zero-extend a pixel into the signed gradient width
    function automatic logic signed [GW-1:0] widen(input logic [PIX_W-1:0] p);
        return $signed({{GRAD_EXTRA{1'b0}}, p});
    endfunction

    // Absolute value of a gradient; |G| <= 4*(2^PIX_W-1) fits AW bits
    function automatic logic [AW-1:0] abs_grad(input logic signed [GW-1:0] g);
        return AW'(g[GW-1] ? -g : g);
    endfunction

    logic [1:0]             state;
    logic [COL_W-1:0]       col;
    logic [ROW_W-1:0]       row;
    logic                   adv;
    logic                   accept;
    logic [PIX_W-1:0]       top_pixel;
    logic [PIX_W-1:0]       mid_pixel;
    logic [PIX_W-1:0]       win [3][3];   // [row: 0=oldest][col: 2=newest]
    logic                   s1_valid;
    logic                   s1_last;
    logic                   s2_valid;
    logic                   s2_last;
    logic signed [GW-1:0]   gx_s;
    logic signed [GW-1:0]   gy_s;
    logic signed [GW-1:0]   gx_r;
    logic signed [GW-1:0]   gy_r;
    logic [AW-1:0]          ax;
    logic [AW-1:0]          ay;
    logic [AW-1:0]          hi;
    logic [AW-1:0]          lo;
    logic [GW-1:0]          sum_s;
    logic [PIX_W-1:0]       mag_s;
    logic [PIX_W-1:0]       pix_next;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv && (state == ST_RUN);
    assign accept   = in_valid && in_ready;

    sobel_line_buffer #(
        .IMG_WIDTH (IMG_WIDTH),
        .PIX_W     (PIX_W),
        .COL_W     (COL_W)
    ) u_line_buffer (
        .clka      (clka),
        .wr_en     (accept),
        .col       (col),
        .pixel     (in_pixel),
        .top_pixel (top_pixel),
        .mid_pixel (mid_pixel)
    );

    // Frame control: FSM, raster position, busy/done and cycle counter
    always_ff @(posedge clka or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            col         <= '0;
            row         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cycle_count <= 32'd0;
        end else begin
            done <= 1'b0;
            if (busy) begin
                cycle_count <= cycle_count + 32'd1;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state       <= ST_RUN;
                        busy        <= 1'b1;
                        cycle_count <= 32'd0;
                        col         <= '0;
                        row         <= '0;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        if (col == COL_LAST) begin
                            col <= '0;
                            if (row == ROW_LAST) begin
                                state <= ST_DRAIN;
                            end else begin
                                row <= row + ROW_ONE;
                            end
                        end else begin
                            col <= col + COL_ONE;
                        end
                    end
                end
                ST_DRAIN: begin
                    // The final beat leaves only after every earlier stage emptied
                    if (out_valid && out_ready && out_last && !s1_valid && !s2_valid) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Gradients from the registered window: right minus left, bottom minus top
    always_comb begin
        gx_s = '0;
        gy_s = '0;
        gx_s = (widen(win[0][2]) + (widen(win[1][2]) <<< 1) + widen(win[2][2]))
             - (widen(win[0][0]) + (widen(win[1][0]) <<< 1) + widen(win[2][0]));
        gy_s = (widen(win[2][0]) + (widen(win[2][1]) <<< 1) + widen(win[2][2]))
             - (widen(win[0][0]) + (widen(win[0][1]) <<< 1) + widen(win[0][2]));
    end

    // Magnitude from registered gradients, saturated, optionally thresholded
    always_comb begin
        ax       = abs_grad(gx_r);
        ay       = abs_grad(gy_r);
        hi       = ax;
        lo       = ay;
        sum_s    = '0;
        mag_s    = '0;
        pix_next = '0;
        if (ax >= ay) begin
            hi = ax;
            lo = ay;
        end else begin
            hi = ay;
            lo = ax;
        end
        if (MAG_MODE == MAG_SUM) begin
            sum_s = {1'b0, ax} + {1'b0, ay};
        end else begin
            sum_s = {1'b0, hi} + ({1'b0, lo} >> 1);
        end
        if (sum_s > SAT_MAX) begin
            mag_s = {PIX_W{1'b1}};
        end else begin
            mag_s = sum_s[PIX_W-1:0];
        end
`ifdef SOBEL_THRESH_EN
        if (mag_s >= thresh) begin
            pix_next = {PIX_W{1'b1}};
        end else begin
            pix_next = {PIX_W{1'b0}};
        end
`else
        pix_next = mag_s;
`endif
    end

    // Three-stage datapath; everything advances together only when adv is high
    always_ff @(posedge clka or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win[i][j] <= '0;
                end
            end
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s2_valid  <= 1'b0;
            s2_last   <= 1'b0;
            gx_r      <= '0;
            gy_r      <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_pixel <= '0;
        end else if (adv) begin
            // S1: window shift; only interior centres produce an output
            s1_valid <= accept && (row >= ROW_TWO) && (col >= COL_TWO);
            s1_last  <= accept && (row == ROW_LAST) && (col == COL_LAST);
            if (accept) begin
                for (int i = 0; i < 3; i++) begin
                    win[i][0] <= win[i][1];
                    win[i][1] <= win[i][2];
                end
                win[0][2] <= top_pixel;
                win[1][2] <= mid_pixel;
                win[2][2] <= in_pixel;
            end
            // S2: gradients
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            gx_r     <= gx_s;
            gy_r     <= gy_s;
            // S3: output register
            out_valid <= s2_valid;
            out_last  <= s2_valid && s2_last;
            if (s2_valid) begin
                out_pixel <= pix_next;
            end
        end
    end

endmodule
